// File: rtl/keccak_round_sequencer.sv
// Round/step sequencer for an iterative Keccak permutation core.
// Issues one step unit at a time, loads the state once per round.
module keccak_round_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int NUM_STEPS  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_STEPS-1:0] stepReady,
    output logic [NUM_STEPS-1:0] stepStart,
    output logic [2:0]           stepIdx,
    output logic [4:0]           roundIdx,
    output logic                 ldState,
    output logic                 selInput,
    output logic                 ready,
    output logic                 done
);

    localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS - 1);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [NUM_STEPS-1:0] UNIT0 = NUM_STEPS'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;
    logic   sel_ready;

    // Only the ready flag of the unit being awaited matters.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (stepIdx == 3'(i)) begin
                sel_ready = stepReady[i];
            end
        end
    end

    // State, counters and outputs; each output register holds the
    // Moore decode of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            stepIdx   <= 3'd0;
            roundIdx  <= 5'd0;
            stepStart <= '0;
            ldState   <= 1'b0;
            selInput  <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            stepStart <= '0;
            ldState   <= 1'b0;
            selInput  <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        ldState  <= 1'b1;
                        selInput <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    stepIdx   <= 3'd0;
                    roundIdx  <= 5'd0;
                    state     <= S_ISSUE;
                    stepStart <= UNIT0;
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sel_ready) begin
                        if (stepIdx < LAST_STEP) begin
                            stepIdx   <= stepIdx + 3'd1;
                            state     <= S_ISSUE;
                            stepStart <= UNIT0 << (stepIdx + 3'd1);
                        end else begin
                            state   <= S_ROUND;
                            ldState <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    stepIdx <= 3'd0;
                    if (roundIdx == LAST_ROUND) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        roundIdx  <= roundIdx + 5'd1;
                        state     <= S_ISSUE;
                        stepStart <= UNIT0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    stepIdx <= 3'd0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

    // At most one unit is started per cycle.
    a_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(stepStart));

    // Counters stay inside their legal ranges.
    a_step_rng: assert property (
        @(posedge clk) disable iff (rst) stepIdx <= LAST_STEP);
    a_round_rng: assert property (
        @(posedge clk) disable iff (rst) roundIdx <= LAST_ROUND);

    // Completion is always followed by a return to idle.
    a_done_idle: assert property (
        @(posedge clk) disable iff (rst) done |=> ready);

    // Ready is exclusive with every other action output.
    a_ready_excl: assert property (
        @(posedge clk) disable iff (rst)
        ready |-> !(ldState || done || (stepStart != '0)));

endmodule

// File: doc/keccak_round_sequencer.md
KECCAK_ROUND_SEQUENCER -- requirements
Module: keccak_round_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 24, meaning the number of permutation rounds per operation (legal range 1..31).
REQ-002 The block SHALL have parameter NUM_STEPS, default 5, meaning the number of step units per round (theta, rho, pi, chi, iota), in fixed order 0..NUM_STEPS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new permutation; sampled only in IDLE.
REQ-006 The block SHALL have port stepReady, input, NUM_STEPS bits: per-unit idle/ready flag from each step controller.
REQ-007 The block SHALL have port stepStart, output, NUM_STEPS bits: one-hot, one-cycle start pulse to the selected step unit.
REQ-008 The block SHALL have port stepIdx, output, 3 bits: index of the step currently issued or awaited.
REQ-009 The block SHALL have port roundIdx, output, 5 bits: current round number, which addresses the round-constant ROM.
REQ-010 The block SHALL have port ldState, output, 1 bit: load enable for the main state register.
REQ-011 The block SHALL have port selInput, output, 1 bit: state-register mux select (1 = external input, 0 = round result).
REQ-012 The block SHALL have port ready, output, 1 bit: high while in IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The block SHALL implement a Moore FSM with states IDLE, LOAD, ISSUE, WAIT, ROUND, DONE; all outputs SHALL be decoded from the present state and the counters only.
REQ-015 In IDLE, the FSM SHALL assert ready and go to LOAD when start=1, otherwise stay in IDLE.
REQ-016 In LOAD, the FSM SHALL assert ldState=1 and selInput=1, clear the step and round counters to 0, and go to ISSUE.
REQ-017 In ISSUE, the FSM SHALL assert stepStart[stepIdx]=1 (all other bits 0) and go to WAIT; stepReady SHALL be ignored in ISSUE.
REQ-018 In WAIT, the FSM SHALL stay in WAIT while stepReady[stepIdx]=0; on 1, it SHALL go to ISSUE with stepIdx+1 if stepIdx<NUM_STEPS-1, otherwise go to ROUND.
REQ-019 Step units SHALL drop their ready no later than the cycle after their start pulse; a unit that keeps ready high SHALL cause an immediate advance from WAIT (no deadlock).
REQ-020 In ROUND, the FSM SHALL assert ldState=1 with selInput=0 and clear stepIdx; if roundIdx=NUM_ROUNDS-1 it SHALL go to DONE, else it SHALL increment roundIdx and go to ISSUE.
REQ-021 In DONE, the FSM SHALL assert done=1 for exactly one cycle and go to IDLE; roundIdx SHALL hold its final value until the next LOAD.
REQ-022 stepReady bits other than stepIdx SHALL be ignored in every state.
REQ-023 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-024 The counters SHALL never wrap: stepIdx ranges 0..NUM_STEPS-1 and roundIdx ranges 0..NUM_ROUNDS-1.
REQ-025 For units that hold ready low D cycles after start, total latency SHALL be 1+NUM_ROUNDS*(NUM_STEPS*(D+2)+1) cycles from the edge that samples start to the edge entering DONE.
REQ-026 Undefined state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 While rst=1, the FSM SHALL be forced to IDLE, stepIdx=0, roundIdx=0, stepStart=0, ldState=0, selInput=0, done=0 and ready=1, asynchronously and at any point in an operation.
REQ-028 After rst deasserts, no stepStart pulse SHALL occur until a new start is accepted.

Verification
REQ-029 A bench SHALL check: reset, start=1 for one cycle, all units D=3, NUM_ROUNDS=2 -> done on the edge 53 cycles after start is sampled; exactly 10 stepStart pulses in order 0,1,2,3,4,0,...; ldState high 3 times.
REQ-030 A bench SHALL check: default NUM_ROUNDS=24, D=3 -> done after 625 cycles; roundIdx steps 0..23; selInput=1 only in the first ldState cycle.
REQ-031 A bench SHALL check: unit 2 ready held low 20 cycles in round 0 -> FSM stays in WAIT with stepIdx=2 and no stepStart for those cycles, then resumes.
REQ-032 A bench SHALL check: start held high through the operation and on the DONE cycle -> no restart until IDLE; a new operation begins one cycle after the return to IDLE.
REQ-033 A bench SHALL check: rst pulsed mid-WAIT in round 7 -> outputs reach their reset values immediately and ready=1; a subsequent start runs the full sequence from round 0.
REQ-034 A bench SHALL check: a non-selected stepReady toggling during WAIT -> no advance.
